// File: rtl/vec_mem_map_pkg.sv
// vec_mem_map_pkg: memory map of the vector CPU data-memory controller.
//   - I/O register word offsets from IO_BASE
//   - region_t: decoded target of a CPU access
//   - STATUS register bit positions and a packing helper
package vec_mem_map_pkg;

    localparam logic [31:0] TXDATA_OFF = 32'd0;
    localparam logic [31:0] STATUS_OFF = 32'd1;
    localparam logic [31:0] RDCNT_OFF  = 32'd2;
    localparam logic [31:0] WRCNT_OFF  = 32'd3;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TXDATA,
        REG_STATUS,
        REG_RDCNT,
        REG_WRCNT,
        REG_NONE
    } region_t;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_FULL_BIT  = 30;
    localparam int STAT_EMPTY_BIT = 29;
    localparam int STAT_CNT_W     = 16;   // count occupies [15:0]

    // STATUS = {overflow, full, empty, 13'b0, count[15:0]}
    function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                                input logic empty,
                                                input logic [STAT_CNT_W-1:0] cnt);
        logic [31:0] w;
        w                 = '0;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_FULL_BIT]  = full;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_CNT_W-1:0] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/vec_data_mem_ctrl_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (pointers/count only)
//   push_i, wdata_i - push request and data
//   pop_i           - pop request (ignored while empty)
//   rdata_o         - head entry (0 while empty)
//   full_o, empty_o - occupancy flags
//   count_o         - entries held, 0..DEPTH
//   push_ok_o       - push accepted this cycle (a push when full is
//                     accepted only if a pop happens in the same cycle)
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       push_ok_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             pop_ok;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign count_o   = cnt_q;
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok_o = push_i && (!full_o || pop_ok);

    // Gated so the output reads 0 while nothing is queued, including after reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head slot
    // is overwritten at the same edge it is consumed, which is safe.
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)    rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok_o, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vec_data_mem_ctrl.sv
// vec_data_mem_ctrl: data-memory controller behind the vector CPU data port.
// Word RAM at [0, RAM_DEPTH), I/O window at IO_BASE:
//   +0 TXDATA (write pushes stream FIFO, reads 0)
//   +1 STATUS (read {ovf,full,empty,13'b0,count}; write bit31=1 clears ovf)
//   +2 RDCNT, +3 WRCNT (only with VEC_MEM_STATS_EN; otherwise unmapped)
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cpu_wr_en, cpu_addr, cpu_data - CPU access (every cycle is a read)
//   mem_data            - read data, one cycle after the address
//   out_data, out_valid, out_ready - FWFT stream to the sink
//   overflow            - sticky dropped-push flag
// Build option: define VEC_MEM_STATS_EN to add the read/write counters.
module vec_data_mem_ctrl
    import vec_mem_map_pkg::*;
#(
    parameter int          RAM_DEPTH  = 1024,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic [31:0] mem_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int          RAM_AW   = $clog2(RAM_DEPTH);
    localparam int          FIFO_CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_LIM  = 32'(RAM_DEPTH);

    region_t          region, region_q;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]      ram_q [RAM_DEPTH];
    logic [31:0]      ram_rd_q;
    logic [31:0]      io_rd_d, io_rd_q;
    logic             ovf_q;
    logic             ram_we, push, pop, push_ok, ovf_set, ovf_clr;
    logic             fifo_full, fifo_empty;
    logic [FIFO_CW-1:0] fifo_cnt;

    always_comb begin
        region = REG_NONE;
        if (cpu_addr < RAM_LIM)                       region = REG_RAM;
        else if (cpu_addr == IO_BASE + TXDATA_OFF)    region = REG_TXDATA;
        else if (cpu_addr == IO_BASE + STATUS_OFF)    region = REG_STATUS;
`ifdef VEC_MEM_STATS_EN
        else if (cpu_addr == IO_BASE + RDCNT_OFF)     region = REG_RDCNT;
        else if (cpu_addr == IO_BASE + WRCNT_OFF)     region = REG_WRCNT;
`endif
    end

    assign ram_idx = cpu_addr[RAM_AW-1:0];
    // A write presented during the reset cycle is discarded.
    assign ram_we  = cpu_wr_en && !reset && (region == REG_RAM);
    assign push    = cpu_wr_en && !reset && (region == REG_TXDATA);
    assign pop     = out_valid && out_ready;
    assign ovf_set = push && !push_ok;
    assign ovf_clr = cpu_wr_en && (region == REG_STATUS) && cpu_data[STAT_OVF_BIT];

    // Read-first RAM: the registered read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= cpu_data;
        ram_rd_q <= ram_q[ram_idx];
    end

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .wdata_i   (cpu_data),
        .pop_i     (pop),
        .rdata_o   (out_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt),
        .push_ok_o (push_ok)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;

`ifdef VEC_MEM_STATS_EN
    logic [31:0] rdcnt_q, wrcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdcnt_q <= '0;
            wrcnt_q <= '0;
        end else begin
            if (!cpu_wr_en && region == REG_RAM) rdcnt_q <= rdcnt_q + 1'b1;
            if (ram_we || push_ok)               wrcnt_q <= wrcnt_q + 1'b1;
        end
    end
`endif

    // I/O read data is captured with pre-update state, so a STATUS read in
    // the same cycle as a push/pop/clear reports the old values.
    always_comb begin
        io_rd_d = '0;
        case (region)
            REG_STATUS: io_rd_d = status_word(ovf_q, fifo_full, fifo_empty,
                                              {{(STAT_CNT_W-FIFO_CW){1'b0}}, fifo_cnt});
`ifdef VEC_MEM_STATS_EN
            REG_RDCNT:  io_rd_d = rdcnt_q;
            REG_WRCNT:  io_rd_d = wrcnt_q;
`endif
            default:    io_rd_d = '0;
        endcase
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            region_q <= REG_NONE;
            io_rd_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            region_q <= region;
            io_rd_q  <= io_rd_d;
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    // region_q resets to REG_NONE, so mem_data reads 0 out of reset.
    assign mem_data = (region_q == REG_RAM) ? ram_rd_q : io_rd_q;

endmodule

// File: tb/tb_vec_data_mem_ctrl.sv
// Testbench for vec_data_mem_ctrl: table of hand-computed vectors, hand
// sequences for FIFO full/overflow/reset corners, then random stimulus checked
// against a queue/array reference model.
module tb_vec_data_mem_ctrl;
    localparam logic [31:0] IO = 32'hFFFF_FF00;
    localparam int          FD = 16;

    logic        clk = 1'b0;
    logic        reset, cpu_wr_en, out_ready, out_valid, overflow;
    logic [31:0] cpu_addr, cpu_data, mem_data, out_data;

    vec_data_mem_ctrl dut (
        .clk(clk), .reset(reset), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .mem_data(mem_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_ram [int unsigned];
    logic [31:0] m_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_mem = '0;
    logic        m_mem_known = 1'b0;
    logic        m_live = 1'b0;
    logic [31:0] m_rdcnt = '0, m_wrcnt = '0;

    // outputs observed in the most recent step
    logic [31:0] obs_mem, obs_data;
    logic        obs_valid, obs_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, observe/check at negedge, advance model, cross posedge.
    task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic rst = 1'b0);
        logic [31:0] nxt;
        logic        known, pop, push, full, acc;
        cpu_wr_en = wr; cpu_addr = a; cpu_data = d; out_ready = rdy; reset = rst;
        @(negedge clk);
        obs_mem = mem_data; obs_data = out_data; obs_valid = out_valid; obs_ovf = overflow;
        if (m_live) begin
            if (m_mem_known) chk("model mem_data", obs_mem, m_mem);
            chk("model out_valid", {31'b0, obs_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) chk("model out_data", obs_data, m_q[0]);
            chk("model overflow", {31'b0, obs_ovf}, {31'b0, m_ovf});
        end
        if (rst) begin
            m_q.delete(); m_ovf = 0; m_mem = 0; known = 1; m_rdcnt = 0; m_wrcnt = 0;
            m_live = 1;
        end else begin
            known = 1; nxt = 0;
            if (a < 1024) begin
                known = m_ram.exists(a);
                if (known) nxt = m_ram[a];
            end else if (a == IO + 1)
                nxt = {m_ovf, m_q.size() == FD, m_q.size() == 0, 13'b0, 16'(m_q.size())};
`ifdef VEC_MEM_STATS_EN
            else if (a == IO + 2) nxt = m_rdcnt;
            else if (a == IO + 3) nxt = m_wrcnt;
`endif
            m_mem = nxt;
            pop  = (m_q.size() != 0) && rdy;
            push = wr && (a == IO);
            full = (m_q.size() == FD);
            acc  = push && (!full || pop);
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(d);
            if (push && !acc) m_ovf = 1;
            else if (wr && a == IO + 1 && d[31]) m_ovf = 0;
            if (wr && a < 1024) m_ram[a] = d;
            if (!wr && a < 1024) m_rdcnt++;
            if ((wr && a < 1024) || acc) m_wrcnt++;
        end
        m_mem_known = known;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        chk_mem;
        logic [31:0] exp_mem;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic wr, logic [31:0] a, logic [31:0] d, logic rdy,
                                logic cm, logic [31:0] em, logic ev, logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.rdy = rdy; v.chk_mem = cm;
        v.exp_mem = em; v.exp_valid = ev; v.exp_data = ed; v.exp_ovf = 1'b0;
        return v;
    endfunction

    initial begin
        // expected values are the outputs seen during that row's cycle
        tbl[0]  = mk(1, 5,      32'hDEAD_BEEF, 0, 1, 0,             0, 0);
        tbl[1]  = mk(0, 5,      0,             0, 0, 0,             0, 0);
        tbl[2]  = mk(0, 5000,   0,             0, 1, 32'hDEAD_BEEF, 0, 0);
        tbl[3]  = mk(1, 7,      1,             0, 1, 0,             0, 0);
        tbl[4]  = mk(1, 7,      2,             0, 0, 0,             0, 0);
        tbl[5]  = mk(0, 7,      0,             0, 1, 1,             0, 0);
        tbl[6]  = mk(1, IO,     10,            0, 1, 2,             0, 0);
        tbl[7]  = mk(1, IO,     20,            0, 1, 0,             1, 10);
        tbl[8]  = mk(1, IO,     30,            0, 1, 0,             1, 10);
        tbl[9]  = mk(0, IO + 1, 0,             0, 1, 0,             1, 10);
        tbl[10] = mk(0, 32'h1234, 0,           1, 1, 32'h0000_0003, 1, 10);
        tbl[11] = mk(0, 32'h1234, 0,           1, 1, 0,             1, 20);
        tbl[12] = mk(0, 32'h1234, 0,           1, 1, 0,             1, 30);
        tbl[13] = mk(0, IO + 1, 0,             1, 1, 0,             0, 0);
        tbl[14] = mk(0, 0,      0,             0, 1, 32'h2000_0000, 0, 0);

        step(0, 0, 0, 0, 1);
        chk("reset mem_data", mem_data, 0);
        chk("reset out_valid", {31'b0, out_valid}, 0);
        chk("reset overflow", {31'b0, overflow}, 0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].rdy);
            if (tbl[i].chk_mem) chk($sformatf("vec%0d mem_data", i), obs_mem, tbl[i].exp_mem);
            chk($sformatf("vec%0d out_valid", i), {31'b0, obs_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) chk($sformatf("vec%0d out_data", i), obs_data, tbl[i].exp_data);
            chk($sformatf("vec%0d overflow", i), {31'b0, obs_ovf}, {31'b0, tbl[i].exp_ovf});
        end

        // fill, overflow, clear
        for (int i = 0; i < FD; i++) step(1, IO, 100 + i, 0);
        step(1, IO, 999, 0);
        step(0, IO + 1, 0, 0);
        chk("ovf set", {31'b0, obs_ovf}, 1);
        step(0, 0, 0, 0);
        chk("status full+ovf", obs_mem, 32'hC000_0010);
        step(1, IO + 1, 32'h8000_0000, 0);
        step(0, IO + 1, 0, 0);
        chk("ovf clear", {31'b0, obs_ovf}, 0);

        // push while full with a simultaneous pop
        step(1, IO, 99, 1);
        chk("full pop head", obs_data, 100);
        step(0, IO + 1, 0, 0);
        chk("full pop next head", obs_data, 101);
        chk("full pop no ovf", {31'b0, obs_ovf}, 0);
        step(0, 0, 0, 0);
        chk("full pop status", obs_mem, 32'h4000_0010);

        // overflow again, drain to 5, then reset with a write in the reset cycle
        step(1, IO, 7, 0);
        for (int i = 0; i < 11; i++) step(0, 32'h1234, 0, 1);
        step(0, IO + 1, 0, 0);
        step(0, 32'h1234, 0, 0);
        chk("pre-reset status", obs_mem, 32'h8000_0005);
        step(1, 5, 32'h55, 0, 1);
        step(0, IO + 1, 0, 0);
        chk("post-reset valid", {31'b0, obs_valid}, 0);
        chk("post-reset ovf", {31'b0, obs_ovf}, 0);
        chk("post-reset mem", obs_mem, 0);
        step(0, 5, 0, 0);
        chk("post-reset status", obs_mem, 32'h2000_0000);
        step(0, 0, 0, 0);
        chk("reset-cycle write dropped", obs_mem, 32'hDEAD_BEEF);

`ifdef VEC_MEM_STATS_EN
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, i, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 20 + i, i, 0);
        step(0, IO + 2, 0, 0);
        step(0, IO + 3, 0, 0);
        chk("rdcnt", obs_mem, 4);
        step(0, 32'h1234, 0, 0);
        chk("wrcnt", obs_mem, 2);
`endif

        // random phase, model-checked every cycle
        for (int i = 0; i < 16; i++) step(1, i, $urandom, 0);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            logic        wr, rdy, rst;
            case ($urandom_range(0, 7))
                0, 1, 2: a = $urandom_range(0, 15);
                3, 4:    a = IO;
                5:       a = IO + 1;
                6:       a = IO + 2 + $urandom_range(0, 1);
                default: a = ($urandom_range(0, 1) != 0) ? 32'd5000 : IO + 4;
            endcase
            wr  = $urandom_range(0, 1);
            d   = $urandom;
            rdy = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step(wr, a, d, rdy, rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
